barrel_shifter_pipe: RTL
========================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter DW, default 8: data width; SHALL be a power of two, 2..64.
REQ-002 Derived localparam SW = log2(DW), default 3: shift-amount width and pipeline depth; not overridable.
REQ-003 i_clk  in  1: single clock; all state changes on its rising edge.
REQ-004 i_rst  in  1: reset, synchronous and active-high.
REQ-005 i_valid  in  1: input beat present.
REQ-006 o_ready  out  1: block accepts an input beat this cycle.
REQ-007 i_data  in  DW: operand.
REQ-008 i_k  in  SW: shift amount, 0..DW-1, unsigned.
REQ-009 i_mode  in  2: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 o_valid  out  1: output beat present.
REQ-011 i_ready  in  1: downstream accepts the output beat.
REQ-012 o_data  out  DW: shifted result.
REQ-013 o_zero  out  1: high when o_data is all zeros; qualified by o_valid.

Function
REQ-014 Input handshake: a beat SHALL transfer on a rising edge where i_valid && o_ready.
REQ-015 Output handshake: a beat SHALL retire on a rising edge where o_valid && i_ready.
REQ-016 Pipeline: SW register stages; stage s (s = 0..SW-1) SHALL apply a shift of 2^s when bit s of the carried k is set, otherwise pass the value through.
REQ-017 Each stage SHALL carry valid, data, k and mode alongside the partial result.
REQ-018 Global advance: adv = !o_valid || i_ready; all stages SHALL load from their predecessor when adv, and hold otherwise.
REQ-019 o_ready SHALL equal adv, combinationally.
REQ-020 Latency: a beat accepted at edge N with adv continuously high SHALL appear with o_valid=1 after edge N+SW-1 and be visible in cycle N+SW.
REQ-021 Throughput: one beat per cycle while i_ready=1.
REQ-022 Bubbles: when i_valid=0 and adv=1, stage 0 SHALL load valid=0; bubbles are not collapsed.
REQ-023 Stall: while adv=0, o_data, o_zero and o_valid SHALL hold stable, and no input beat SHALL be accepted.
REQ-024 SLL: zero fill from the LSB.
REQ-025 SRL: zero fill from the MSB.
REQ-026 SRA: fill from the MSB with i_data[DW-1] of the original operand.
REQ-027 ROR: bits shifted out at the LSB SHALL re-enter at the MSB.
REQ-028 k=0 in any mode SHALL produce o_data = i_data.
REQ-029 Result width is DW; bits shifted out are discarded (except for ROR), with no carry output.
REQ-030 o_zero SHALL be registered in the final stage, coincident with o_data.
REQ-031 Rotate-left is not a mode; callers use ROR with k = (DW-k) mod DW.

Reset
REQ-032 When i_rst=1 at a rising edge, all stage valid bits SHALL clear to 0, with the edge being otherwise ignored.
REQ-033 After reset, o_valid=0 and o_ready=1.
REQ-034 After reset, o_data=0 and o_zero=0.
REQ-035 Reset SHALL take priority over advance.
REQ-036 Reset mid-operation SHALL discard all in-flight beats, with no output produced for them.
REQ-037 No input beat SHALL be accepted on a reset edge.

Structure
REQ-038 Mode encodings (SLL/SRL/SRA/ROR) SHALL be shared constants in package barrel_shifter_pkg, used by both RTL and bench.
REQ-039 One sub-module, barrel_shift_stage, SHALL implement a single registered mux layer, parametrised by DW and stage index.
REQ-040 barrel_shifter_pipe SHALL generate SW instances of barrel_shift_stage, chained in order.
REQ-041 Control logic (adv, o_ready) SHALL reside in the top level.
REQ-042 No latches and no multi-cycle paths.

Verification (DW=8, SW=3)
REQ-043 SLL: i_data=0x81, k=1, i_ready=1 -> o_data=0x02, o_zero=0 at cycle N+3.
REQ-044 SRA: 0x80, k=3 -> 0xF0; SRL: 0x80, k=7 -> 0x01; ROR: 0x81, k=1 -> 0xC0; SLL: 0x80, k=1 -> 0x00 with o_zero=1.
REQ-045 Backpressure: stream 4 beats while i_ready=0 from cycle 2 for 5 cycles -> o_ready low after the pipe fills, o_data held stable, no beat lost or duplicated, order preserved.
REQ-046 Reset mid-stream: assert i_rst with 3 beats in flight -> o_valid=0 next cycle and those beats never appear.
REQ-047 Random: 1000 random beats with random i_valid/i_ready and all modes, including k=0 -> every result matches the reference model, in order.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// Shared constants for the pipelined barrel shifter: shift mode encodings.
package barrel_shifter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered mux layer of the barrel shifter. Stage STAGE shifts the
// partial result by 2^STAGE when bit STAGE of the carried shift amount is set,
// and carries valid, original operand, shift amount and mode to the next layer.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int STAGE = 0,
  localparam int SW    = $clog2(DW)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adv,
  input  logic              i_valid,
  input  logic [DW-1:0]     i_orig,
  input  logic [DW-1:0]     i_partial,
  input  logic [SW-1:0]     i_k,
  input  logic [MODE_W-1:0] i_mode,
  output logic              o_valid,
  output logic [DW-1:0]     o_orig,
  output logic [DW-1:0]     o_partial,
  output logic [SW-1:0]     o_k,
  output logic [MODE_W-1:0] o_mode,
  output logic              o_zero
);

  localparam int SHIFT = 1 << STAGE;

  logic [DW-1:0] w_fill;
  logic [DW-1:0] w_shifted;
  logic [DW-1:0] w_next;

  logic              r_valid;
  logic [DW-1:0]     r_orig;
  logic [DW-1:0]     r_partial;
  logic [SW-1:0]     r_k;
  logic [MODE_W-1:0] r_mode;
  logic              r_zero;

  // Shift by this layer's fixed distance; SRA fills with the original operand's sign.
  always_comb begin
    w_fill    = '0;
    w_shifted = i_partial;
    if (i_mode == MODE_SRA) begin
      w_fill = {DW{i_orig[DW-1]}};
    end
    case (i_mode)
      MODE_SLL: w_shifted = i_partial << SHIFT;
      MODE_SRL,
      MODE_SRA: w_shifted = (i_partial >> SHIFT) | (w_fill << (DW - SHIFT));
      default:  w_shifted = (i_partial >> SHIFT) | (i_partial << (DW - SHIFT));
    endcase
    w_next = i_k[STAGE] ? w_shifted : i_partial;
  end

  // Load from the previous layer on advance, hold on stall, clear on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_orig    <= '0;
      r_partial <= '0;
      r_k       <= '0;
      r_mode    <= '0;
      r_zero    <= 1'b0;
    end else if (i_adv) begin
      r_valid   <= i_valid;
      r_orig    <= i_orig;
      r_partial <= w_next;
      r_k       <= i_k;
      r_mode    <= i_mode;
      r_zero    <= (w_next == '0);
    end
  end

  assign o_valid   = r_valid;
  assign o_orig    = r_orig;
  assign o_partial = r_partial;
  assign o_k       = r_k;
  assign o_mode    = r_mode;
  assign o_zero    = r_zero;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: log2(DW) registered layers with a single global
// advance. The whole pipe moves when the output slot is empty or being taken.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter  int DW = 8,
  localparam int SW = $clog2(DW)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DW-1:0]     i_data,
  input  logic [SW-1:0]     i_k,
  input  logic [MODE_W-1:0] i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DW-1:0]     o_data,
  output logic              o_zero
);

  logic              w_adv;
  logic              w_valid   [0:SW];
  logic [DW-1:0]     w_orig    [0:SW];
  logic [DW-1:0]     w_partial [0:SW];
  logic [SW-1:0]     w_k       [0:SW];
  logic [MODE_W-1:0] w_mode    [0:SW];
  logic [SW:1]       w_zero;
  logic              w_unusedTail;

  assign w_adv   = !o_valid || i_ready;
  assign o_ready = w_adv;

  assign w_valid[0]   = i_valid;
  assign w_orig[0]    = i_data;
  assign w_partial[0] = i_data;
  assign w_k[0]       = i_k;
  assign w_mode[0]    = i_mode;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    barrel_shift_stage #(
      .DW   (DW),
      .STAGE(s)
    ) u_stage (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_adv    (w_adv),
      .i_valid  (w_valid[s]),
      .i_orig   (w_orig[s]),
      .i_partial(w_partial[s]),
      .i_k      (w_k[s]),
      .i_mode   (w_mode[s]),
      .o_valid  (w_valid[s+1]),
      .o_orig   (w_orig[s+1]),
      .o_partial(w_partial[s+1]),
      .o_k      (w_k[s+1]),
      .o_mode   (w_mode[s+1]),
      .o_zero   (w_zero[s+1])
    );
  end

  assign o_valid = w_valid[SW];
  assign o_data  = w_partial[SW];
  assign o_zero  = w_zero[SW];

  assign w_unusedTail = ^{w_orig[SW], w_k[SW], w_mode[SW], w_zero};

endmodule
